// File: rtl/seg_scan_decoder.sv
// Recovers the four BCD digits shown on a multiplexed active-low
// 7-segment display and publishes them one complete frame at a time.
module seg_scan_decoder #(
  parameter int STABLE_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] num,
  output logic        num_valid,
  output logic        frame_done,
  output logic        seg_err,
  output logic        an_err,
  output logic [7:0]  frame_cnt
);

  localparam logic [7:0] LAST = 8'(STABLE_CYC - 1);
  localparam logic [7:0] TOP  = 8'(STABLE_CYC);

  logic [10:0] s1, s2, prev;
  logic [7:0]  cnt;
  logic [15:0] dig, dig_nxt;
  logic [3:0]  seen, seen_nxt;
  logic [3:0]  an_c;
  logic [6:0]  seg_c;
  logic [3:0]  code;
  logic        bad, same, commit;
  logic        cap_bad, ghost, full;

  assign an_c   = s2[10:7];
  assign seg_c  = s2[6:0];
  assign same   = (s2 == prev);
  assign commit = same && (cnt == LAST);

  always_comb begin
    code = 4'hE;
    bad  = 1'b0;
    case (seg_c)
      7'b1000000: code = 4'h0;
      7'b1111001: code = 4'h1;
      7'b0100100: code = 4'h2;
      7'b0110000: code = 4'h3;
      7'b0011001: code = 4'h4;
      7'b0010010: code = 4'h5;
      7'b0000010: code = 4'h6;
      7'b1111000: code = 4'h7;
      7'b0000000: code = 4'h8;
      7'b0010000: code = 4'h9;
      7'b0111111: code = 4'hF;
      default:    bad  = 1'b1;
    endcase
  end

  // Only a single enabled digit is a capture; blank or ghosted
  // samples leave the digit registers alone.
  always_comb begin
    dig_nxt  = dig;
    seen_nxt = seen;
    cap_bad  = 1'b0;
    ghost    = 1'b0;
    if (commit) begin
      if ($onehot(~an_c)) begin
        for (int k = 0; k < 4; k++) begin
          if (!an_c[k]) dig_nxt[4*k +: 4] = code;
        end
        seen_nxt = seen | ~an_c;
        cap_bad  = bad;
      end else if (an_c != 4'hF) begin
        ghost = 1'b1;
      end
    end
    full = (seen_nxt == 4'hF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
      cnt  <= '0;
    end else begin
      s1   <= {an, seg};
      s2   <= s1;
      prev <= s2;
      if (!same)          cnt <= '0;
      else if (cnt != TOP) cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig        <= '0;
      seen       <= '0;
      num        <= '0;
      num_valid  <= 1'b0;
      frame_done <= 1'b0;
      seg_err    <= 1'b0;
      an_err     <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      dig        <= dig_nxt;
      seen       <= full ? 4'h0 : seen_nxt;
      frame_done <= full;
      seg_err    <= cap_bad;
      an_err     <= ghost;
      if (full) begin
        num       <= dig_nxt;
        num_valid <= 1'b1;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule
